// File: rtl/am_modulator.sv
// am_modulator: standard-AM transmitter, s = (CARRIER_LEVEL + mu*m) * sin(phase).
// Ports: clk, rst (async low), sig_in/in_valid/in_ready, freq_word, sig_out/out_valid/out_ready. Optional AM_CLIP_EN.
module am_modulator #(
  parameter int CARRIER_LEVEL = 32768,
  parameter int MOD_INDEX     = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [63:0] sig_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic        [31:0] freq_word,
  output logic signed [63:0] sig_out,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic signed [63:0] CL = 64'(CARRIER_LEVEL);
  localparam logic signed [63:0] MI = 64'(MOD_INDEX);

  // Quarter-wave table, round(32767*sin(pi/2*j/64)).
  localparam logic [15:0] T [0:64] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,
    16'd4011,  16'd4808,  16'd5602,  16'd6393,  16'd7179,
    16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039,
    16'd11793, 16'd12539, 16'd13279, 16'd14010, 16'd14732,
    16'd15446, 16'd16151, 16'd16846, 16'd17530, 16'd18204,
    16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403,
    16'd22005, 16'd22594, 16'd23170, 16'd23731, 16'd24279,
    16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898,
    16'd29268, 16'd29621, 16'd29956, 16'd30273, 16'd30571,
    16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785,
    16'd31971, 16'd32137, 16'd32285, 16'd32412, 16'd32521,
    16'd32609, 16'd32678, 16'd32728, 16'd32757, 16'd32767
  };

  logic adv;
  logic take;

  // Global stall: every register moves only when the output can drain.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign take     = in_valid && adv;

  logic        [31:0] acc;
  logic               v1, v2, v3;
  logic signed [63:0] env1, env2;
  logic        [7:0]  p1;
  logic signed [16:0] c2;
  logic signed [63:0] prod3;

  logic signed [63:0] scaled;
  logic signed [63:0] env_raw;
  logic signed [63:0] env_nxt;

  always_comb begin
    scaled  = sig_in * MI;
    env_raw = CL + (scaled >>> 10);
`ifdef AM_CLIP_EN
    env_nxt = env_raw[63] ? 64'sd0 : env_raw;
`else
    env_nxt = env_raw;
`endif
  end

  logic        [1:0]  quad;
  logic        [6:0]  idx;
  logic signed [16:0] mag;
  logic signed [16:0] c_nxt;
  logic signed [63:0] c_ext;

  always_comb begin
    quad  = p1[7:6];
    idx   = quad[0] ? (7'd64 - {1'b0, p1[5:0]})
                    : {1'b0, p1[5:0]};
    mag   = $signed({1'b0, T[idx]});
    c_nxt = quad[1] ? -mag : mag;
    c_ext = 64'(c2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      v1   <= 1'b0;
      env1 <= '0;
      p1   <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (take) begin
        env1 <= env_nxt;
        p1   <= acc[31:24];
        acc  <= acc + freq_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2   <= 1'b0;
      env2 <= '0;
      c2   <= '0;
    end else if (adv) begin
      v2   <= v1;
      env2 <= env1;
      c2   <= c_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3    <= 1'b0;
      prod3 <= '0;
    end else if (adv) begin
      v3    <= v2;
      prod3 <= env2 * c_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      sig_out   <= '0;
    end else if (adv) begin
      out_valid <= v3;
      sig_out   <= prod3 >>> 15;
    end
  end

endmodule

// File: tb/tb_am_modulator.sv
// tb_am_modulator: directed vector bench for am_modulator.
// Table-driven stream plus stall, wrap and reset sequences.
module tb_am_modulator;

  logic               clk;
  logic               rst;
  logic signed [63:0] sig_in;
  logic               in_valid;
  logic               in_ready;
  logic        [31:0] freq_word;
  logic signed [63:0] sig_out;
  logic               out_valid;
  logic               out_ready;

  am_modulator dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .freq_word (freq_word),
    .sig_out   (sig_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint s;
    logic [31:0] f;
    longint e;
  } vec_t;

`ifdef AM_CLIP_EN
  localparam longint CLP_A = 0;
  localparam longint CLP_B = 0;
`else
  localparam longint CLP_A = -32767;
  localparam longint CLP_B = 32767;
`endif

  int     n_vec = 0;
  int     n_bad = 0;
  int     n_out = 0;
  longint cur_exp = 0;
  longint expq [$];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(output bit took);
    longint e;
    #1;
    took = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious: got %0d want no output", sig_out);
      end else begin
        e = expq.pop_front();
        chk($sformatf("sample%0d", n_out), sig_out, e);
        n_out++;
      end
    end
    if (took) expq.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit t;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && expq.size() > 0; k++) step(t);
    chk("drain_left", longint'(expq.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t   tv [24];
  longint bp [8];
  bit     took;
  longint hold;
  int     i, cyc, base;

  initial begin
    tv[0]  = '{0, 32'h4000_0000, 32767};
    tv[1]  = '{0, 32'h4000_0000, 0};
    tv[2]  = '{0, 32'h4000_0000, -32767};
    tv[3]  = '{0, 32'h4000_0000, 0};
    tv[4]  = '{1024, 32'h4000_0000, 33278};
    tv[5]  = '{1024, 32'h4000_0000, 0};
    tv[6]  = '{1024, 32'h4000_0000, -33279};
    tv[7]  = '{1024, 32'h4000_0000, 0};
    tv[8]  = '{-131072, 32'h4000_0000, CLP_A};
    tv[9]  = '{-131072, 32'h4000_0000, 0};
    tv[10] = '{-131072, 32'h4000_0000, CLP_B};
    tv[11] = '{5, 32'h4000_0000, 0};
    tv[12] = '{-1, 32'h0800_0000, 32766};
    tv[13] = '{0, 32'h0800_0000, 32137};
    tv[14] = '{0, 32'h0000_0000, 30273};
    tv[15] = '{0, 32'h4000_0000, 30273};
    tv[16] = '{0, 32'h3000_0000, -12539};
    tv[17] = '{0, 32'h4000_0000, -32767};
    tv[18] = '{0, 32'hC000_0000, 0};
    tv[19] = '{0, 32'hC000_0000, -32767};
    tv[20] = '{0, 32'hC000_0000, 0};
    tv[21] = '{0, 32'hC000_0000, 32767};
    tv[22] = '{0, 32'hC000_0000, 0};
    tv[23] = '{0, 32'hC000_0000, -32767};
    bp = '{0, -12539, -23170, -30273,
           -32767, -30273, -23170, -12539};

    rst       = 1'b0;
    in_valid  = 1'b0;
    sig_in    = '0;
    freq_word = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sig_out", sig_out, 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", longint'(in_ready), 1);

    // First sample: phase 0, latency of three edges.
    in_valid  = 1'b1;
    sig_in    = 0;
    freq_word = 32'h4000_0000;
    cur_exp   = 0;
    step(took);
    chk("lat_accept", longint'(took), 1);
    in_valid = 1'b0;
    step(took);
    chk("lat_e1", longint'(out_valid), 0);
    step(took);
    chk("lat_e2", longint'(out_valid), 0);
    step(took);
    chk("lat_e3", longint'(out_valid), 1);
    drain();

    // Back-to-back table stream.
    foreach (tv[k]) begin
      in_valid  = 1'b1;
      sig_in    = tv[k].s;
      freq_word = tv[k].f;
      cur_exp   = tv[k].e;
      #1;
      chk($sformatf("stream_rdy%0d", k), longint'(in_ready), 1);
      step(took);
    end
    drain();
    chk("table_count", longint'(n_out), 25);

    // Backpressure: 5-cycle stall mid-stream.
    base = n_out;
    i    = 0;
    cyc  = 0;
    hold = 0;
    while ((i < 8 || expq.size() > 0) && cyc < 60) begin
      in_valid  = (i < 8);
      sig_in    = 0;
      freq_word = 32'h1000_0000;
      cur_exp   = bp[(i < 8) ? i : 0];
      out_ready = !(cyc >= 5 && cyc <= 9);
      if (cyc == 5) hold = sig_out;
      #1;
      if (cyc >= 5 && cyc <= 9)
        chk($sformatf("stall_rdy%0d", cyc), longint'(in_ready), 0);
      if (cyc >= 6 && cyc <= 10) begin
        chk($sformatf("stall_hold%0d", cyc), sig_out, hold);
        chk($sformatf("stall_ov%0d", cyc), longint'(out_valid), 1);
      end
      step(took);
      if (took) i++;
      cyc++;
    end
    out_ready = 1'b1;
    chk("bp_count", longint'(n_out - base), 8);
    chk("bp_left", longint'(expq.size()), 0);

    // Reset with samples in flight.
    for (int k = 0; k < 5; k++) begin
      in_valid  = 1'b1;
      sig_in    = 0;
      freq_word = 32'h4000_0000;
      cur_exp   = (k == 1) ? 32767 : ((k == 3) ? -32767 : 0);
      step(took);
    end
    in_valid = 1'b0;
    chk("pre_rst_ov", longint'(out_valid), 1);
    chk("pre_rst_out", sig_out, 32767);
    rst = 1'b0;
    #1;
    chk("mid_rst_ov", longint'(out_valid), 0);
    chk("mid_rst_out", sig_out, 0);
    chk("mid_rst_rdy", longint'(in_ready), 1);
    expq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    base = n_out;
    in_valid  = 1'b1;
    freq_word = 32'h4000_0000;
    cur_exp   = 0;
    step(took);
    cur_exp   = 32767;
    step(took);
    drain();
    chk("post_rst_count", longint'(n_out - base), 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
